// File: rtl/ysyx_22041211_lsu_axi_master_if.sv
// Core request/response and AXI-lite AR/R/AW/W/B bundle for the LSU master.
// master modport is the LSU view; slave modport is the core + memory-side view.
interface ysyx_22041211_lsu_axi_master_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_LEN-1:0]   req_addr;
  logic [DATA_LEN-1:0]   req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  rsp_valid;
  logic [DATA_LEN-1:0]   rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_LEN-1:0]   addr_r_addr;
  logic                  addr_r_valid;
  logic                  addr_r_ready;
  logic [DATA_LEN-1:0]   r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_LEN-1:0]   addr_w_addr;
  logic                  addr_w_valid;
  logic                  addr_w_ready;
  logic [DATA_LEN-1:0]   w_data;
  logic [DATA_LEN/8-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            bkwd_resp;
  logic                  bkwd_valid;
  logic                  bkwd_ready;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output addr_r_addr, addr_r_valid, input addr_r_ready,
    input  r_data, r_resp, r_valid, output r_ready,
    output addr_w_addr, addr_w_valid, input addr_w_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  bkwd_resp, bkwd_valid, output bkwd_ready
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  addr_r_addr, addr_r_valid, output addr_r_ready,
    output r_data, r_resp, r_valid, input r_ready,
    input  addr_w_addr, addr_w_valid, output addr_w_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output bkwd_resp, bkwd_valid, input bkwd_ready
  );
endinterface

// File: rtl/ysyx_22041211_lsu_axi_master.sv
// Single-outstanding AXI-lite LSU master: lane placement on stores, extension on loads; response 3 cycles after accept
// with a zero-wait slave, no response backpressure. YSYX_22041211_LSU_MISALIGN_CHECK_EN enables misalignment faulting.
module ysyx_22041211_lsu_axi_master #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_22041211_lsu_axi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_LEN-1:0] rsp_rdata_q;
  logic                accept, misalign;
  logic [1:0]          ofs;
  logic [DATA_LEN-1:0] sh, load_data, st_data;
  logic [3:0]          st_strb;

`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
  assign misalign = (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                    (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign accept = bus.req_valid && bus.req_ready;
  assign ofs    = addr_q[1:0];

  always_comb begin
    state_nxt         = state;
    aw_done_nxt       = aw_done;
    w_done_nxt        = w_done;
    bus.req_ready     = 1'b0;
    bus.addr_r_valid  = 1'b0;
    bus.r_ready       = 1'b0;
    bus.addr_w_valid  = 1'b0;
    bus.w_valid       = 1'b0;
    bus.bkwd_ready    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          // Hold off new work while the previous response pulse is on the wire.
          bus.req_ready = !rsp_valid_q;
          if (bus.req_valid && !rsp_valid_q && !misalign) begin
            state_nxt   = bus.req_wen ? WR_REQ : RD_ADDR;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end
        end
        RD_ADDR: begin
          bus.addr_r_valid = 1'b1;
          if (bus.addr_r_ready) state_nxt = RD_DATA;
        end
        RD_DATA: begin
          bus.r_ready = 1'b1;
          if (bus.r_valid) state_nxt = IDLE;
        end
        WR_REQ: begin
          bus.addr_w_valid = !aw_done;
          bus.w_valid      = !w_done;
          if (bus.addr_w_valid && bus.addr_w_ready) aw_done_nxt = 1'b1;
          if (bus.w_valid && bus.w_ready) w_done_nxt = 1'b1;
          if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
        end
        WR_RESP: begin
          bus.bkwd_ready = 1'b1;
          if (bus.bkwd_valid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    st_data = wdata_q;
    st_strb = 4'b1111;
    unique case (size_q)
      2'd0: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << ofs;
      end
      2'd1: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << {ofs[1], 1'b0};
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  assign sh = bus.r_data >> {ofs, 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_data = uns_q ? {{(DATA_LEN-8){1'b0}}, sh[7:0]}
                                 : {{(DATA_LEN-8){sh[7]}}, sh[7:0]};
      2'd1:    load_data = uns_q ? {{(DATA_LEN-16){1'b0}}, sh[15:0]}
                                 : {{(DATA_LEN-16){sh[15]}}, sh[15:0]};
      default: load_data = bus.r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
      rsp_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
      end
      if (accept && misalign) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
      if (state == RD_DATA && bus.r_valid) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= |bus.r_resp;
        rsp_rdata_q <= load_data;
      end
      if (state == WR_RESP && bus.bkwd_valid) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= |bus.bkwd_resp;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.addr_r_addr = {addr_q[ADDR_LEN-1:2], 2'b00};
  assign bus.addr_w_addr = {addr_q[ADDR_LEN-1:2], 2'b00};
  assign bus.w_data      = st_data;
  assign bus.w_strb      = st_strb;
endmodule

// File: tb/tb_ysyx_22041211_lsu_axi_master.sv
// Directed bench for the LSU AXI-lite master: vector table plus hand-written handshake/reset sequences.
module tb_ysyx_22041211_lsu_axi_master;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu_axi_master_if bus ();

  ysyx_22041211_lsu_axi_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] sdata;
    logic [1:0]  resp;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    bus.req_wen      = wen;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] got_addr, got_wd, got_rd;
    logic [3:0]  got_strb;
    logic        got_err, got_rdy, saw_ar, saw_aw;
    int          rsp_cyc;
    got_addr = 'x; got_wd = 'x; got_rd = 'x; got_strb = 'x; got_err = 'x; got_rdy = 'x;
    saw_ar = 1'b0; saw_aw = 1'b0; rsp_cyc = 0;
    bus.r_data    = v.sdata;
    bus.r_resp    = v.resp;
    bus.bkwd_resp = v.resp;
    bus.req_wen = v.wen; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    bus.req_size = v.size; bus.req_unsigned = v.uns; bus.req_valid = 1'b1;
    #1 check($sformatf("v%0d req_ready_idle", idx), {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.addr_r_valid) begin saw_ar = 1'b1; got_addr = bus.addr_r_addr; end
      if (bus.addr_w_valid) begin saw_aw = 1'b1; got_addr = bus.addr_w_addr; end
      if (bus.w_valid) begin got_wd = bus.w_data; got_strb = bus.w_strb; end
      if (bus.rsp_valid && rsp_cyc == 0) begin
        rsp_cyc = c; got_rd = bus.rsp_rdata; got_err = bus.rsp_err; got_rdy = bus.req_ready;
      end
    end
    check($sformatf("v%0d bus_addr", idx), got_addr, v.e_addr);
    check($sformatf("v%0d ar_used", idx), {31'b0, saw_ar}, {31'b0, !v.wen});
    check($sformatf("v%0d aw_used", idx), {31'b0, saw_aw}, {31'b0, v.wen});
    check($sformatf("v%0d rsp_cycle", idx), rsp_cyc, 32'd3);
    check($sformatf("v%0d rsp_rdata", idx), got_rd, v.e_rdata);
    check($sformatf("v%0d rsp_err", idx), {31'b0, got_err}, {31'b0, v.e_err});
    check($sformatf("v%0d ready_in_rsp", idx), {31'b0, got_rdy}, 32'd0);
    if (v.wen) begin
      check($sformatf("v%0d w_data", idx), got_wd, v.e_wdata);
      check($sformatf("v%0d w_strb", idx), {28'b0, got_strb}, {28'b0, v.e_strb});
    end
  endtask

  initial begin
    vec_t vecs[13];
    int   bcount, rcount;
    //           wen  addr          wdata         sz    uns   sdata         resp   e_addr        e_wdata       strb     e_rdata       err
    vecs[0]  = '{1'b0, 32'h8000_0004, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h8000_0004, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b0, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0,         4'h0,    32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b1, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0,         4'h0,    32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0002, 32'h0,         2'd1, 1'b0, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0,         4'h0,    32'hFFFF_80FF, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0,         2'd1, 1'b1, 32'h1234_F00D, 2'b00, 32'h8000_0000, 32'h0,         4'h0,    32'h0000_F00D, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0001, 32'h0,         2'd0, 1'b0, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0,         4'h0,    32'h0000_0012, 1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0,         2'd2, 1'b0, 32'h1122_3344, 2'b10, 32'h8000_0010, 32'h0,         4'h0,    32'h1122_3344, 1'b1};
    vecs[7]  = '{1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 32'h0,         2'b00, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0001, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,         2'b00, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h8000_000C, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0,         2'b00, 32'h8000_000C, 32'hCAFE_F00D, 4'b1111, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h8000_0007, 32'h0000_005A, 2'd0, 1'b0, 32'h0,         2'b11, 32'h8000_0004, 32'h5A5A_5A5A, 4'b1000, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h8000_0004, 32'hFFFF_0001, 2'd1, 1'b0, 32'h0,         2'b00, 32'h8000_0004, 32'h0001_0001, 4'b0011, 32'h0,         1'b0};
    vecs[12] = '{1'b1, 32'h8000_0008, 32'h0102_0304, 2'd3, 1'b0, 32'h0,         2'b00, 32'h8000_0008, 32'h0102_0304, 4'b1111, 32'h0,         1'b0};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.addr_r_ready = 1'b0; bus.r_data = '0; bus.r_resp = '0; bus.r_valid = 1'b0;
    bus.addr_w_ready = 1'b0; bus.w_ready = 1'b0;
    bus.bkwd_resp = '0; bus.bkwd_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst ar_valid", {31'b0, bus.addr_r_valid}, 32'd0);
    check("rst aw_w_valid", {30'b0, bus.addr_w_valid, bus.w_valid}, 32'd0);
    check("rst r_b_ready", {30'b0, bus.r_ready, bus.bkwd_ready}, 32'd0);
    check("rst rsp", {31'b0, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("post_rst rsp_rdata", bus.rsp_rdata, 32'd0);

    // Zero-wait slave for the table.
    bus.addr_r_ready = 1'b1; bus.r_valid = 1'b1;
    bus.addr_w_ready = 1'b1; bus.w_ready = 1'b1; bus.bkwd_valid = 1'b1;
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // W ready delayed three cycles after the AW handshake.
    bus.w_ready = 1'b0; bus.bkwd_valid = 1'b0; bus.bkwd_resp = 2'b00;
    issue(1'b1, 32'h8000_0020, 32'h1122_3344, 2'd2, 1'b0);
    @(negedge clk);
    check("dlyw c1 valids", {30'b0, bus.addr_w_valid, bus.w_valid}, 32'd3);
    @(negedge clk);
    check("dlyw c2 valids", {30'b0, bus.addr_w_valid, bus.w_valid}, 32'd1);
    check("dlyw c2 w_data", bus.w_data, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    check("dlyw c4 valids", {30'b0, bus.addr_w_valid, bus.w_valid}, 32'd1);
    check("dlyw c4 w_data", bus.w_data, 32'h1122_3344);
    check("dlyw c4 no_bready", {31'b0, bus.bkwd_ready}, 32'd0);
    bus.w_ready = 1'b1; bus.bkwd_valid = 1'b1;
    bcount = 0; rcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.bkwd_ready && bus.bkwd_valid) bcount++;
      if (bus.rsp_valid) rcount++;
    end
    check("dlyw b_accepts", bcount, 32'd1);
    check("dlyw rsp_pulses", rcount, 32'd1);

    // Reset while waiting in RD_DATA.
    bus.r_valid = 1'b0; bus.bkwd_valid = 1'b0;
    issue(1'b0, 32'h8000_0040, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid r_ready", {31'b0, bus.r_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid valids", {27'b0, bus.addr_r_valid, bus.r_ready, bus.addr_w_valid, bus.w_valid, bus.bkwd_ready}, 32'd0);
    rst = 1'b0; bus.r_valid = 1'b1; bus.r_data = 32'h5555_AAAA;
    @(negedge clk);
    check("rstmid idle_ready", {31'b0, bus.req_ready}, 32'd1);
    rcount = 0; bcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.rsp_valid) rcount++;
      if (bus.r_ready || bus.addr_r_valid) bcount++;
      @(negedge clk);
    end
    check("rstmid no_rsp", rcount, 32'd0);
    check("rstmid no_bus", bcount, 32'd0);

    // Misaligned word load.
    bus.r_resp = 2'b00;
    issue(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
    @(negedge clk);
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
    check("mis ar_valid", {31'b0, bus.addr_r_valid}, 32'd0);
    check("mis rsp", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd3);
    check("mis rdata", bus.rsp_rdata, 32'd0);
`else
    check("mis ar_valid", {31'b0, bus.addr_r_valid}, 32'd1);
    check("mis ar_addr", bus.addr_r_addr, 32'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    check("mis rsp", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("mis rdata", bus.rsp_rdata, 32'h5555_AAAA);
`endif
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
